// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
//
// Game sequencer for the Pong datapath. Owns the ball position and direction,
// moves the ball once per video frame, resolves paddle hits/misses and wall
// bounces, keeps score, runs the serve countdown and detects game over.
// paddle_en gates both paddle blocks.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   frame_tick  in   one-cycle pulse per frame (start of vertical blank)
//   start_btn   in   debounced start level (rising edge detected here)
//   paddle_l_y  in   [9:0] left paddle centre y
//   paddle_r_y  in   [9:0] right paddle centre y
//   ball_x      out  [9:0] ball centre x (registered)
//   ball_y      out  [9:0] ball centre y (registered)
//   score_l     out  [3:0] left player score
//   score_r     out  [3:0] right player score
//   paddle_en   out  1 = paddles may move
//   point_l     out  one-cycle pulse when left scores
//   point_r     out  one-cycle pulse when right scores
//   game_over   out  high while in GAME_OVER
//   state       out  [2:0] IDLE=0 SERVE=1 PLAY=2 POINT=3 GAME_OVER=4
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_STEP    = 2,
  parameter int BALL_HALF    = 4,
  parameter int PADDLE_HALF  = 50,
  parameter int LEFT_X       = 20,
  parameter int RIGHT_X      = 620,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       paddle_en,
  output logic       point_l,
  output logic       point_r,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0] CENTRE_X     = 10'(SCREEN_W / 2);
  localparam logic [9:0] CENTRE_Y     = 10'(SCREEN_H / 2);
  localparam logic [9:0] Y_BOTTOM     = 10'(SCREEN_H - 1 - BALL_HALF);
  localparam logic [9:0] Y_TOP        = 10'(BALL_HALF);
  localparam logic [9:0] X_LEFT_FACE  = 10'(LEFT_X + BALL_HALF);
  localparam logic [9:0] X_RIGHT_FACE = 10'(RIGHT_X - BALL_HALF);
  localparam logic [9:0] STEP         = 10'(BALL_STEP);
  localparam logic [3:0] WIN          = 4'(WIN_SCORE);

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Thresholds kept in a 12-bit signed domain so the paddle window can go
  // negative (paddle near the top) or past 1023 without wrapping.
  localparam logic signed [11:0] STEP_S       = signed'(12'(BALL_STEP));
  localparam logic signed [11:0] Y_BOTTOM_S   = signed'(12'(SCREEN_H - 1 - BALL_HALF));
  localparam logic signed [11:0] Y_TOP_LIM_S  = signed'(12'(BALL_HALF + BALL_STEP));
  localparam logic signed [11:0] X_LEFT_LIM_S = signed'(12'(LEFT_X + BALL_HALF + BALL_STEP));
  localparam logic signed [11:0] X_RGHT_LIM_S = signed'(12'(RIGHT_X - BALL_HALF));
  localparam logic signed [11:0] PAD_HALF_S   = signed'(12'(PADDLE_HALF));

  function automatic logic signed [11:0] widen(input logic [9:0] v);
    return signed'({2'b00, v});
  endfunction

  // Half-open window [pad - half, pad + half) around the paddle centre.
  function automatic logic in_paddle(input logic [9:0] pad_y, input logic [9:0] by);
    logic signed [11:0] p;
    logic signed [11:0] b;
    p = widen(pad_y);
    b = widen(by);
    return (b >= (p - PAD_HALF_S)) && (b < (p + PAD_HALF_S));
  endfunction

  state_e           state_q, state_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic             dir_x_q, dir_x_d;     // 1 = moving right
  logic             dir_y_q, dir_y_d;     // 1 = moving down
  logic [3:0]       score_l_q, score_l_d;
  logic [3:0]       score_r_q, score_r_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic             point_l_q, point_l_d;
  logic             point_r_q, point_r_d;
  logic             scorer_l_q, scorer_l_d; // who took the last point
  logic             start_q;
  logic             start_rise;

  logic [9:0]       y_step, x_step;
  logic             dir_y_step, dir_x_step;
  logic             miss_l, miss_r;       // miss_l: left player failed to return

  assign start_rise = start_btn & ~start_q;

  // Candidate ball motion for one frame; only committed in PLAY on frame_tick.
  // Both contact tests use the pre-update ball_y.
  always_comb begin
    y_step     = ball_y_q;
    dir_y_step = dir_y_q;
    if (dir_y_q) begin
      if ((widen(ball_y_q) + STEP_S) >= Y_BOTTOM_S) begin
        y_step     = Y_BOTTOM;
        dir_y_step = 1'b0;
      end else begin
        y_step = ball_y_q + STEP;
      end
    end else begin
      if (widen(ball_y_q) <= Y_TOP_LIM_S) begin
        y_step     = Y_TOP;
        dir_y_step = 1'b1;
      end else begin
        y_step = ball_y_q - STEP;
      end
    end

    x_step     = ball_x_q;
    dir_x_step = dir_x_q;
    miss_l     = 1'b0;
    miss_r     = 1'b0;
    if (!dir_x_q) begin
      if (widen(ball_x_q) <= X_LEFT_LIM_S) begin
        if (in_paddle(paddle_l_y, ball_y_q)) begin
          x_step     = X_LEFT_FACE;
          dir_x_step = 1'b1;
        end else begin
          miss_l = 1'b1;
        end
      end else begin
        x_step = ball_x_q - STEP;
      end
    end else begin
      if ((widen(ball_x_q) + STEP_S) >= X_RGHT_LIM_S) begin
        if (in_paddle(paddle_r_y, ball_y_q)) begin
          x_step     = X_RIGHT_FACE;
          dir_x_step = 1'b0;
        end else begin
          miss_r = 1'b1;
        end
      end else begin
        x_step = ball_x_q + STEP;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_cnt_d = serve_cnt_q;
    scorer_l_d  = scorer_l_q;
    point_l_d   = 1'b0;
    point_r_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        ball_x_d = CENTRE_X;
        ball_y_d = CENTRE_Y;
        // A coincident frame_tick is deliberately not looked at here.
        if (start_rise) begin
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          serve_cnt_d = SERVE_LOAD;
          state_d     = S_SERVE;
        end
      end

      S_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_q == CNT_ONE) begin
            state_d = S_PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q - CNT_ONE;
          end
        end
      end

      S_PLAY: begin
        if (frame_tick) begin
          ball_x_d = x_step;
          ball_y_d = y_step;
          dir_x_d  = dir_x_step;
          dir_y_d  = dir_y_step;
          if (miss_l) begin
            score_r_d  = score_r_q + 4'd1;
            point_r_d  = 1'b1;
            scorer_l_d = 1'b0;
            state_d    = S_POINT;
          end else if (miss_r) begin
            score_l_d  = score_l_q + 4'd1;
            point_l_d  = 1'b1;
            scorer_l_d = 1'b1;
            state_d    = S_POINT;
          end
        end
      end

      S_POINT: begin
        if (scorer_l_q ? (score_l_q == WIN) : (score_r_q == WIN)) begin
          state_d = S_GAME_OVER;
        end else begin
          // Serve toward the player who conceded; vertical direction carries over.
          ball_x_d    = CENTRE_X;
          ball_y_d    = CENTRE_Y;
          dir_x_d     = scorer_l_q;
          serve_cnt_d = SERVE_LOAD;
          state_d     = S_SERVE;
        end
      end

      S_GAME_OVER: begin
        if (start_rise) begin
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          ball_x_d    = CENTRE_X;
          ball_y_d    = CENTRE_Y;
          dir_x_d     = 1'b1;
          dir_y_d     = 1'b1;
          serve_cnt_d = SERVE_LOAD;
          state_d     = S_SERVE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ball_x_q    <= CENTRE_X;
      ball_y_q    <= CENTRE_Y;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      serve_cnt_q <= '0;
      point_l_q   <= 1'b0;
      point_r_q   <= 1'b0;
      scorer_l_q  <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_cnt_q <= serve_cnt_d;
      point_l_q   <= point_l_d;
      point_r_q   <= point_r_d;
      scorer_l_q  <= scorer_l_d;
      start_q     <= start_btn;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign point_l   = point_l_q;
  assign point_r   = point_r_q;
  assign state     = state_q;
  assign paddle_en = (state_q == S_SERVE) || (state_q == S_PLAY) || (state_q == S_POINT);
  assign game_over = (state_q == S_GAME_OVER);

endmodule
